// File: rtl/pipeline_sequencer_if.sv
// Handshake bundle between the ID-stage decode/command source and the pipeline sequencer.
// The master drives commands and decoded fields; the sequencer (slave) returns stage enables.
interface pipeline_sequencer_if;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic [5:0] id_opcode;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       ex_mem_read;
    logic [4:0] ex_rt;
    logic       pipe_en;
    logic       pc_en;
    logic       ifid_en;
    logic       idex_flush;

    modport master (
        output cmd_valid, cmd, id_opcode, id_rs, id_rt, ex_mem_read, ex_rt,
        input  pipe_en, pc_en, ifid_en, idex_flush
    );

    modport slave (
        input  cmd_valid, cmd, id_opcode, id_rs, id_rt, ex_mem_read, ex_rt,
        output pipe_en, pc_en, ifid_en, idex_flush
    );
endinterface

// File: rtl/pipeline_sequencer.sv
// Run-control and hazard sequencer for a 5-stage MIPS pipeline: run/step/stop commands,
// load-use stall bubbles, and an orderly fixed-length drain after a HALT reaches ID.
module pipeline_sequencer #(
    parameter logic [5:0]  HALT_OPCODE  = 6'h3F,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_sequencer_if.slave  bus,
    output logic [2:0]           state,
    output logic [CNT_W-1:0]     cycle_count,
    output logic                 done
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StRun   = 3'd1;
    localparam logic [2:0] StStep  = 3'd2;
    localparam logic [2:0] StDrain = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    localparam logic [1:0] CmdRun  = 2'b01;
    localparam logic [1:0] CmdStep = 2'b10;
    localparam logic [1:0] CmdStop = 2'b11;

    localparam int unsigned DrainW = $clog2(DRAIN_CYCLES) + 1;
    localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_CYCLES - 1);

    logic [2:0]        state_q, state_d;
    logic [DrainW-1:0] drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;

    logic halt_id;
    logic stall;
    logic issuing;
    logic enabled;
    logic in_drain;

    always_comb begin
        halt_id  = (bus.id_opcode == HALT_OPCODE);
        stall    = bus.ex_mem_read & (bus.ex_rt != 5'd0) &
                   ((bus.ex_rt == bus.id_rs) | (bus.ex_rt == bus.id_rt));
        issuing  = (state_q == StRun) | (state_q == StStep);
        in_drain = (state_q == StDrain);
        enabled  = issuing | in_drain;
    end

    // Outputs are forced low while rst is held so nothing advances during the reset cycle.
    assign bus.pipe_en    = enabled & ~rst;
    assign bus.pc_en      = issuing & ~stall & ~halt_id & ~rst;
    assign bus.ifid_en    = issuing & ~stall & ~halt_id & ~rst;
    assign bus.idex_flush = ((issuing & (stall | halt_id)) | in_drain) & ~rst;
    assign state          = rst ? StIdle : state_q;
    assign cycle_count    = rst ? '0 : cycle_count_q;
    assign done           = (state_q == StDone) & ~rst;

    always_comb begin
        state_d       = state_q;
        drain_cnt_d   = drain_cnt_q;
        cycle_count_d = cycle_count_q + CNT_W'(enabled);
        case (state_q)
            StIdle: begin
                if (bus.cmd_valid && bus.cmd == CmdRun) begin
                    state_d = StRun;
                end else if (bus.cmd_valid && bus.cmd == CmdStep) begin
                    state_d = StStep;
                end
            end
            StRun: begin
                // STOP wins over a HALT decoded in the same cycle.
                if (bus.cmd_valid && bus.cmd == CmdStop) begin
                    state_d = StIdle;
                end else if (halt_id && !stall) begin
                    state_d     = StDrain;
                    drain_cnt_d = '0;
                end
            end
            StStep: begin
                if (halt_id && !stall) begin
                    state_d     = StDrain;
                    drain_cnt_d = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                drain_cnt_d = drain_cnt_q + DrainW'(1);
                if (drain_cnt_q == DrainLast) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            drain_cnt_q   <= '0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            cycle_count_q <= cycle_count_d;
        end
    end

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
- Run-control and hazard sequencer for the 5-stage MIPS pipeline.
- Sits beside the ID stage and consumes that stage's decoded opcode, rs and rt fields together with EX-stage load information.
- Drives the global stage enable, the PC and IF/ID write enables, and the ID/EX bubble insertion.
- Implements run/step/stop debug commands, load-use stall detection, and an orderly pipeline drain on a HALT instruction.

Parameters:
- HALT_OPCODE, 6'h3F, opcode value identifying the HALT instruction in ID.
- DRAIN_CYCLES, 4, number of enabled cycles after HALT detection before DONE.
- CNT_W, 32, width of the cycle counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command strobe, sampled each cycle.
- cmd  input  2  command: 00 NOP, 01 RUN, 10 STEP, 11 STOP.
- id_opcode  input  6  opcode of the instruction in ID.
- id_rs  input  5  rs field of the instruction in ID.
- id_rt  input  5  rt field of the instruction in ID.
- ex_mem_read  input  1  the instruction in EX is a load.
- ex_rt  input  5  destination rt of the instruction in EX.
- pipe_en  output  1  global enable for the ID/EX, EX/MEM and MEM/WB registers and the register file.
- pc_en  output  1  PC write enable.
- ifid_en  output  1  IF/ID register write enable.
- idex_flush  output  1  load a bubble (all-zero control) into ID/EX.
- state  output  3  current state: 0 IDLE, 1 RUN, 2 STEP, 3 DRAIN, 4 DONE.
- cycle_count  output  CNT_W  number of cycles with pipe_en=1 since reset.
- done  output  1  high in DONE.

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - state is IDLE, cycle_count is 0, drain counter is 0.
  - All outputs are 0 during and after the reset cycle.
  - Reset overrides every other event, including reset mid-DRAIN or in DONE.
- Combinational helper signals:
  - halt_id = (id_opcode == HALT_OPCODE).
  - stall = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
- Moore enable: pipe_en = 1 in RUN, STEP and DRAIN; 0 in IDLE and DONE.
- Output equations (combinational):
  - pc_en = ifid_en = pipe_en & ~stall & ~halt_id, in RUN and STEP only; 0 in every other state.
  - idex_flush = pipe_en & (stall | halt_id) in RUN and STEP; idex_flush = 1 in DRAIN.
  - Consequence: a HALT is held in IF/ID and never enters EX.
- State transitions:
  - IDLE:
    - cmd_valid & cmd=RUN goes to RUN.
    - cmd_valid & cmd=STEP goes to STEP.
    - Anything else stays in IDLE.
  - RUN:
    - cmd_valid & cmd=STOP goes to IDLE. STOP has priority over halt_id.
    - Otherwise halt_id & ~stall goes to DRAIN.
    - Otherwise stays in RUN.
  - STEP:
    - Exactly one enabled cycle.
    - Next state is DRAIN if halt_id & ~stall, else IDLE.
    - Commands received in STEP are ignored.
  - DRAIN:
    - Fetch is frozen; bubbles are inserted.
    - The drain counter increments each cycle.
    - After DRAIN_CYCLES cycles in DRAIN, goes to DONE.
    - Commands are ignored.
  - DONE:
    - Sticky until rst; all commands are ignored.
- Halt detected while stall=1: the stall is served first; HALT is detected on the following cycle.
- cycle_count:
  - Increments by 1 on each clock edge where pipe_en=1.
  - Wraps modulo 2^CNT_W with no flag.
- Latency:
  - A command accepted at edge N is reflected in state and pipe_en after edge N.
  - STEP produces exactly one pipe_en=1 cycle.
- Load-use stall duration: one cycle. Next cycle the load has left EX, so stall deasserts naturally.

Test Plan:
- Reset, then cmd=RUN for 1 cycle, 10 cycles of NOP-decoded input (id_opcode=0, ex_mem_read=0) -> state=1, pc_en=ifid_en=pipe_en=1, cycle_count=10.
- In IDLE, three STEP commands spaced 3 cycles apart -> exactly 3 single-cycle pipe_en pulses, state returns to 0 after each, cycle_count=3.
- RUN with ex_mem_read=1, ex_rt=5, id_rs=5 for one cycle -> that cycle pc_en=ifid_en=0, idex_flush=1, pipe_en=1. Same with ex_rt=0 -> no stall.
- RUN, id_opcode=6'h3F -> pc_en=0 and idex_flush=1 that cycle, then 4 cycles in DRAIN (idex_flush=1), then state=4, done=1, pipe_en=0. A subsequent cmd=RUN is ignored.
- RUN with cmd=STOP and id_opcode=6'h3F on the same cycle -> next state IDLE (not DRAIN), done=0.
- Assert rst during the 2nd DRAIN cycle -> next cycle state=0, cycle_count=0, all outputs 0.
